index_ea_sequencer: RTL

//  Owns the six MIX index registers rI1..rI6 and sequences effective-address (M) computation.
//  For each accepted instruction it computes M = AA + rIi, with I=0 meaning "no index".

---
 rtl/index_ea_sequencer_pkg.sv | 31 +++
 rtl/index_ea_sequencer_add.sv | 41 ++++
 rtl/index_ea_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/index_ea_sequencer_pkg.sv
// Shared types and constants for the MIX index-register / effective-address sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package index_ea_sequencer_pkg;

    localparam int MAG_W  = 12;
    localparam int N_IDX  = 6;
    localparam int WORD_W = MAG_W + 1;

    // Sign-magnitude MIX value: sign=1 means minus; -0 is a legal, distinct value.
    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } word13_t;

    localparam logic [2:0] IDX_NONE = 3'd0;
    localparam logic [2:0] IDX_BAD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_ADD,
        ST_DONE
    } state_t;

    // True when an index code names a real register (1..N_IDX).
    function automatic logic idx_in_file(input logic [2:0] i);
        return (i != IDX_NONE) && (int'(i) <= N_IDX);
    endfunction

endpackage

// File: rtl/index_ea_sequencer_add.sv
// Combinational 13-bit sign-magnitude adder for M = AA + rIi.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module sm_add13
    import index_ea_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] sum,
    output logic              ovf
);

    word13_t          a_w;
    word13_t          b_w;
    word13_t          sum_w;
    logic [MAG_W:0]   mag_add;

    assign a_w     = a;
    assign b_w     = b;
    assign mag_add = {1'b0, a_w.mag} + {1'b0, b_w.mag};
    assign sum     = sum_w;

    // Same signs add magnitudes; different signs subtract smaller from larger.
    // Ties keep the sign of a, so AA + (+0) returns AA bit-exact, -0 included.
    always_comb begin
        sum_w = '0;
        ovf   = 1'b0;
        if (a_w.sign == b_w.sign) begin
            sum_w.sign = a_w.sign;
            sum_w.mag  = mag_add[MAG_W-1:0];
            ovf        = mag_add[MAG_W];
        end else if (a_w.mag >= b_w.mag) begin
            sum_w.sign = a_w.sign;
            sum_w.mag  = a_w.mag - b_w.mag;
        end else begin
            sum_w.sign = b_w.sign;
            sum_w.mag  = b_w.mag - a_w.mag;
        end
    end

endmodule

// File: rtl/index_ea_sequencer.sv
// Owns index registers rI1..rI6 and sequences M = AA + rIi for each decoded instruction.
// Latency: out_valid rises 3 clocks after the accept edge (counting it); one instruction per 4 clocks.
// Backpressure: in_ready only in IDLE; results hold in DONE until out_ready; writeback never stalls.
module index_ea_sequencer
    import index_ea_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_aa,
    input  logic [2:0]        in_idx,
    input  logic [7:0]        in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_m,
    output logic [7:0]        out_tag,
    output logic              out_ovf,
    output logic              out_badidx,
    input  logic              wr_en,
    input  logic [2:0]        wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [2:0]        rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    state_t      state;
    word13_t     ri_q [N_IDX];
    word13_t     aa_q;
    logic [2:0]  idx_q;
    logic [7:0]  tag_q;
    word13_t     opnd_q;
    word13_t     file_rd;
    word13_t     opnd_next;
    word13_t     dbg_rd;
    logic [WORD_W-1:0] sum;
    logic        sum_ovf;

    // Index file: writeback lands at the clock edge in any state; codes 0 and 7 hit nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_IDX; k++) begin
                ri_q[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < N_IDX; k++) begin
                if (wr_idx == 3'(k + 1)) begin
                    ri_q[k] <= wr_data;
                end
            end
        end
    end

    // Front-panel read: codes with no register read as +0.
    always_comb begin
        dbg_rd = '0;
        for (int k = 0; k < N_IDX; k++) begin
            if (rd_idx == 3'(k + 1)) begin
                dbg_rd = ri_q[k];
            end
        end
    end

    assign rd_data = dbg_rd;

    // Operand select for LATCH: a same-cycle writeback to the latched register wins over the stale copy.
    always_comb begin
        file_rd = '0;
        for (int k = 0; k < N_IDX; k++) begin
            if (idx_q == 3'(k + 1)) begin
                file_rd = ri_q[k];
            end
        end
        opnd_next = file_rd;
        if (wr_en && idx_in_file(idx_q) && (wr_idx == idx_q)) begin
            opnd_next = wr_data;
        end
    end

    sm_add13 u_add (
        .a   (aa_q),
        .b   (opnd_q),
        .sum (sum),
        .ovf (sum_ovf)
    );

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            aa_q       <= '0;
            idx_q      <= IDX_NONE;
            tag_q      <= '0;
            opnd_q     <= '0;
            out_valid  <= 1'b0;
            out_m      <= '0;
            out_tag    <= '0;
            out_ovf    <= 1'b0;
            out_badidx <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        aa_q     <= in_aa;
                        idx_q    <= in_idx;
                        tag_q    <= in_tag;
                        in_ready <= 1'b0;
                        state    <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    opnd_q <= opnd_next;
                    state  <= ST_ADD;
                end
                ST_ADD: begin
                    out_m      <= sum;
                    out_ovf    <= sum_ovf;
                    out_badidx <= (idx_q == IDX_BAD);
                    out_tag    <= tag_q;
                    out_valid  <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
